// File: rtl/bus_dma_initiator.sv
// Single-channel word-copy DMA initiator on the picorv32 native memory bus.
// Ports: clk/resetn; start_i, src_addr_i, dst_addr_i, len_i command;
//   busy_o, done_o, err_o, count_o status; mem_* bus initiator.
//   Optional macro DMA_TIMEOUT_EN adds TIMEOUT_CYCLES and the wait limit.
module bus_dma_initiator #(
   parameter int LEN_W = 16
`ifdef DMA_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] count_o,
   output logic             mem_valid_o,
   input  logic             mem_ready_i,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   output logic [3:0]       mem_wstrb_o,
   input  logic [31:0]      mem_rdata_i
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [31:0]      data_q, data_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             expire;

`ifdef DMA_TIMEOUT_EN
   localparam int WAIT_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WAIT_W-1:0] wait_q, wait_d;
   assign expire = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      data_d  = data_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               src_d  = {src_addr_i[31:2], 2'b00};
               dst_d  = {dst_addr_i[31:2], 2'b00};
               rem_d  = len_i;
               cnt_d  = '0;
               err_d  = 1'b0;
               if (len_i == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RD_REQ;
                  busy_d  = 1'b1;
                  valid_d = 1'b1;
                  addr_d  = {src_addr_i[31:2], 2'b00};
                  wstrb_d = 4'h0;
               end
            end
         end
         RD_REQ, WR_REQ: begin
            if (mem_ready_i) begin
               valid_d = 1'b0;
               wstrb_d = 4'h0;
               if (state_q == RD_REQ) begin
                  data_d  = mem_rdata_i;
                  state_d = RD_GAP;
               end else begin
                  src_d   = src_q + 32'd4;
                  dst_d   = dst_q + 32'd4;
                  cnt_d   = cnt_q + LEN_W'(1);
                  rem_d   = rem_q - LEN_W'(1);
                  state_d = WR_GAP;
               end
            end else if (expire) begin
               // abandon the request; count_o keeps the words done so far
               valid_d = 1'b0;
               wstrb_d = 4'h0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         RD_GAP: begin
            state_d = WR_REQ;
            valid_d = 1'b1;
            addr_d  = dst_q;
            wdata_d = data_q;
            wstrb_d = 4'hF;
         end
         WR_GAP: begin
            if (rem_q == '0) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = RD_REQ;
               valid_d = 1'b1;
               addr_d  = src_q;
               wstrb_d = 4'h0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef DMA_TIMEOUT_EN
      // restarts on every entry into a request state
      wait_d = ((state_d == state_q) &&
                ((state_q == RD_REQ) || (state_q == WR_REQ)))
               ? wait_q + WAIT_W'(1) : '0;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef DMA_TIMEOUT_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef DMA_TIMEOUT_EN
         wait_q  <= wait_d;
`endif
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign count_o     = cnt_q;
   assign mem_valid_o = valid_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wstrb_o = wstrb_q;

endmodule
